// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift/add multiply and restoring divide.
// Build option: define MULDIV_DIV_EN to include DIV/DIVU/REM/REMU; otherwise those return 0 in one cycle.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            kill_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q;
    logic [2:0]            funct3_q;
    logic                  neg_q;
    logic [XLEN-1:0]       b_mag_q;
    logic [2*XLEN-1:0]     prod_q;

    logic                  accept;
    logic                  a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]       a_mag, b_mag;
    logic                  neg_d;
    logic                  special;
    logic [XLEN-1:0]       special_res;

    logic [XLEN:0]         mul_sum;
    logic [2*XLEN-1:0]     mul_next;
    logic [2*XLEN-1:0]     mul_res64;
    logic [XLEN-1:0]       mul_res;
    logic [XLEN-1:0]       sign_res;

`ifdef MULDIV_DIV_EN
    logic [XLEN:0]         rem_q;
    logic [XLEN-1:0]       quot_q;
    logic [XLEN+1:0]       rem_sh, trial;
    logic [XLEN:0]         rem_next;
    logic [XLEN-1:0]       quot_next;
    logic [XLEN-1:0]       div_mag, div_res;
    logic                  div_by_zero, div_ovf;
`endif

    assign accept = (state_q == IDLE) && start_i && !kill_i;

    // Operand signedness: multiplies by funct3[1:0], divides by funct3[0].
    assign a_signed = funct3_i[2] ? !funct3_i[0] : (funct3_i[1:0] != 2'b11);
    assign b_signed = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
    assign a_neg    = a_signed && op_a_i[XLEN-1];
    assign b_neg    = b_signed && op_b_i[XLEN-1];
    assign a_mag    = a_neg ? -op_a_i : op_a_i;
    assign b_mag    = b_neg ? -op_b_i : op_b_i;
    assign neg_d    = (funct3_i[2] && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);

`ifdef MULDIV_DIV_EN
    assign div_by_zero = funct3_i[2] && (op_b_i == '0);
    assign div_ovf     = funct3_i[2] && !funct3_i[0] &&
                         (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
    assign special     = div_by_zero || div_ovf;
    assign special_res = div_by_zero ? (funct3_i[1] ? op_a_i : '1)
                                     : (funct3_i[1] ? '0 : op_a_i);
`else
    assign special     = funct3_i[2];
    assign special_res = '0;
`endif

    // One multiply step: add |b| into the high half when the next multiplier bit is set, then shift right.
    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? b_mag_q : '0)};
    assign mul_next  = {mul_sum, prod_q[XLEN-1:1]};
    assign mul_res64 = neg_q ? -prod_q : prod_q;
    assign mul_res   = (funct3_q == 3'b000) ? mul_res64[XLEN-1:0] : mul_res64[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
    // One restoring divide step; trial keeps an extra top bit so its sign shows a failed subtract.
    assign rem_sh    = {rem_q, quot_q[XLEN-1]};
    assign trial     = rem_sh - {2'b00, b_mag_q};
    assign rem_next  = trial[XLEN+1] ? rem_sh[XLEN:0] : trial[XLEN:0];
    assign quot_next = {quot_q[XLEN-2:0], !trial[XLEN+1]};
    assign div_mag   = funct3_q[1] ? rem_q[XLEN-1:0] : quot_q;
    assign div_res   = neg_q ? -div_mag : div_mag;
    assign sign_res  = funct3_q[2] ? div_res : mul_res;
`else
    assign sign_res  = mul_res;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = special ? DONE : CALC;
            CALC: if (count_q == '0) state_d = SIGN;
            SIGN: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i) state_d = IDLE;
    end

    assign stall_o = (((state_q == IDLE) && start_i) || (state_q == CALC) || (state_q == SIGN)) && !kill_i;
    assign busy_o  = (state_q != IDLE);
    assign valid_o = (state_q == DONE) && !kill_i;

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    // NOTE: reset is synchronous and clears the datapath too, keeping results deterministic after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            b_mag_q  <= '0;
            prod_q   <= '0;
            result_o <= '0;
`ifdef MULDIV_DIV_EN
            rem_q    <= '0;
            quot_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        funct3_q <= funct3_i;
                        neg_q    <= neg_d;
                        b_mag_q  <= b_mag;
                        count_q  <= CNT_W'(XLEN - 1);
                        prod_q   <= {{XLEN{1'b0}}, a_mag};
`ifdef MULDIV_DIV_EN
                        quot_q   <= a_mag;
                        rem_q    <= '0;
`endif
                        if (special) result_o <= special_res;
                    end
                end
                CALC: begin
                    count_q <= count_q - CNT_W'(1);
`ifdef MULDIV_DIV_EN
                    if (funct3_q[2]) begin
                        rem_q  <= rem_next;
                        quot_q <= quot_next;
                    end else begin
                        prod_q <= mul_next;
                    end
`else
                    prod_q <= mul_next;
`endif
                end
                SIGN: begin
                    if (!kill_i) result_o <= sign_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table plus stall, kill and reset sequences.
// Divide expectations follow the MULDIV_DIV_EN build option.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        kill_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        stall_o, busy_o, valid_o;
    logic [31:0] result_o;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    muldiv_seq #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .kill_i   (kill_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp, input int lat);
        vec_t v;
        v.name = n; v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    // Divide vector: without the divide build every divide returns 0 after one cycle.
    function automatic vec_t mkd(input string n, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp, input bit spec);
        return mk(n, f3, a, b, DIV_EN ? exp : 32'h0, DIV_EN ? (spec ? 1 : 34) : 1);
    endfunction

    // Waits from the cycle after start for valid_o; lat = -1 if it never comes.
    task automatic wait_valid(output logic [31:0] res, output int lat);
        lat = -1;
        res = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (valid_o) begin
                lat = k;
                res = result_o;
                break;
            end
        end
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        funct3_i = f3;
        op_a_i   = a;
        op_b_i   = b;
        start_i  = 1'b1;
        wait_valid(res, lat);
    endtask

    logic [31:0] res;
    int          lat;
    int          stall_cnt, valid_cnt;

    initial begin
        vecs[0]  = mk ("mul_7_m3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        vecs[1]  = mk ("mulhu_ff_ff",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        vecs[2]  = mk ("mulh_ff_ff",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
        vecs[3]  = mk ("mulhsu_ff_ff",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        vecs[4]  = mk ("mul_3_4",       3'b000, 32'd3,        32'd4,        32'd12,       34);
        vecs[5]  = mk ("mulhu_min_min", 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        vecs[6]  = mk ("mulh_min_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        vecs[7]  = mk ("mulh_min_1",    3'b001, 32'h80000000, 32'd1,        32'hFFFFFFFF, 34);
        vecs[8]  = mk ("mul_big",       3'b000, 32'h12345678, 32'h00010000, 32'h56780000, 34);
        vecs[9]  = mkd("div_m7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
        vecs[10] = mkd("rem_m7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
        vecs[11] = mkd("divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14,       1'b0);
        vecs[12] = mkd("remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2,        1'b0);
        vecs[13] = mkd("divu_5_0",      3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
        vecs[14] = mkd("remu_5_0",      3'b111, 32'd5,        32'd0,        32'd5,        1'b1);
        vecs[15] = mkd("div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        vecs[16] = mkd("rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        vecs[17] = mkd("div_10_2",      3'b100, 32'd10,       32'd2,        32'd5,        1'b0);
        vecs[18] = mkd("rem_m5_0",      3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1);
        vecs[19] = mk ("mul_after_div", 3'b000, 32'd5,        32'd5,        32'd25,       34);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_stall",  32'(stall_o), 32'd0);
        check("rst_busy",   32'(busy_o),  32'd0);
        check("rst_valid",  32'(valid_o), 32'd0);
        check("rst_result", result_o,     32'd0);
        rst = 1'b0;

        // MUL 7 x -3: stall over T..T+33, single valid pulse at T+34
        @(negedge clk);
        funct3_i = 3'b000; op_a_i = 32'd7; op_b_i = 32'hFFFFFFFD; start_i = 1'b1;
        #1;
        stall_cnt = stall_o ? 1 : 0;
        valid_cnt = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (stall_o) stall_cnt++;
            if (valid_o) valid_cnt++;
        end
        check("trace_stall_cycles", 32'(stall_cnt), 32'd34);
        check("trace_early_valid",  32'(valid_cnt), 32'd0);
        @(negedge clk);
        check("trace_valid_t34",  32'(valid_o), 32'd1);
        check("trace_stall_t34",  32'(stall_o), 32'd0);
        check("trace_result_t34", result_o,     32'hFFFFFFEB);
        @(negedge clk);
        check("trace_valid_t35", 32'(valid_o), 32'd0);
        check("trace_busy_t35",  32'(busy_o),  32'd0);
        check("trace_hold_t35",  result_o,     32'hFFFFFFEB);

        // Vector table, back to back
        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat);
            check({vecs[i].name, "_result"},  res,      vecs[i].exp);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
        end

        // Kill at T+10 under MUL; result 25 from the last vector must survive
        @(negedge clk);
        funct3_i = 3'b000; op_a_i = 32'd9; op_b_i = 32'd9; start_i = 1'b1;
        valid_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (valid_o) valid_cnt++;
        end
        @(negedge clk);
        kill_i = 1'b1;
        #1;
        check("kill_stall_t10", 32'(stall_o), 32'd0);
        @(negedge clk);
        kill_i = 1'b0;
        if (valid_o) valid_cnt++;
        check("kill_busy_t11",   32'(busy_o),    32'd0);
        check("kill_no_valid",   32'(valid_cnt), 32'd0);
        check("kill_result_kept", result_o,      32'd25);
        funct3_i = 3'b000; op_a_i = 32'd3; op_b_i = 32'd4; start_i = 1'b1;
        wait_valid(res, lat);
        check("restart_result",  res,      32'd12);
        check("restart_latency", 32'(lat), 32'd34);

        // Kill overrides a start in the same IDLE cycle
        @(negedge clk);
        funct3_i = 3'b000; op_a_i = 32'd2; op_b_i = 32'd2; start_i = 1'b1; kill_i = 1'b1;
        #1;
        check("killstart_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        start_i = 1'b0; kill_i = 1'b0;
        check("killstart_busy", 32'(busy_o), 32'd0);

        // Reset at T+5 under MUL
        @(negedge clk);
        funct3_i = 3'b000; op_a_i = 32'd6; op_b_i = 32'd7; start_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",   32'(busy_o),  32'd0);
        check("midrst_stall",  32'(stall_o), 32'd0);
        check("midrst_valid",  32'(valid_o), 32'd0);
        check("midrst_result", result_o,     32'd0);
        valid_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_o) valid_cnt++;
        end
        check("midrst_no_pulse", 32'(valid_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
